// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// hazard_pkg : shared opcodes, forwarding selects and FSM states
// Rev 1.0
// ============================================================================
package hazard_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    REGF = 2'b00,
    MEM  = 2'b01,
    WB   = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MDU_WAIT = 2'd2
  } hz_state_e;

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
`default_nettype none
// ============================================================================
// hazard_fwd_sel : operand source select for one E-stage source register
// Rev 1.0
// ============================================================================
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rd_m,
  input  logic       i_wr_m,
  input  logic [4:0] i_rd_w,
  input  logic       i_wr_w,
  output logic [1:0] o_sel
);

  fwd_sel_e w_sel;

  // M is checked first so the youngest producer wins
  always_comb begin
    w_sel = REGF;
    if (i_wr_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs)) begin
      w_sel = MEM;
    end else if (i_wr_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs)) begin
      w_sel = WB;
    end
  end

  assign o_sel = w_sel;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : forwarding, load-use stall, redirect flush and MDU wait control
// Rev 1.0
// ============================================================================
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter bit MDU_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_D,
  input  logic [31:0] instr_E,
  input  logic [31:0] instr_M,
  input  logic [31:0] instr_W,
  input  logic        reg_wr_en_E,
  input  logic        reg_wr_en_M,
  input  logic        reg_wr_en_W,
  input  logic        is_taken,
  input  logic        mdu_busy,
  input  logic        mdu_done,
  output logic [1:0]  forward_opA,
  output logic [1:0]  forward_opB,
  output logic        pc_enable,
  output logic        IF_ID_enable,
  output logic        ID_EX_enable,
  output logic        EX_ME_enable,
  output logic        ME_WB_enable,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        EX_ME_flush,
  output logic        ME_WB_flush,
  output logic [1:0]  hz_state
);

  localparam logic [1:0] LD_INIT = 2'(LOAD_STALL - 1);

  hz_state_e  r_state, w_state_nxt;
  logic [1:0] r_cnt, w_cnt_nxt;

  logic [1:0] w_fwd_a, w_fwd_b;
  logic       w_load_use, w_redirect, w_mdu_stall;
  logic       w_pc_en, w_ifid_en, w_idex_en, w_exme_en, w_mewb_en;
  logic       w_ifid_fl, w_idex_fl, w_exme_fl, w_mewb_fl;

  wire [6:0] w_opc_E = instr_E[6:0];
  wire [4:0] w_rd_E  = instr_E[11:7];

  wire w_unused_bits = ^{instr_D[31:25], instr_D[14:0], instr_E[31:25],
                         instr_E[14:12], instr_M[31:12], instr_M[6:0],
                         instr_W[31:12], instr_W[6:0]};

  hazard_fwd_sel u_fwd_a (
    .i_rs   (instr_E[19:15]),
    .i_rd_m (instr_M[11:7]),
    .i_wr_m (reg_wr_en_M),
    .i_rd_w (instr_W[11:7]),
    .i_wr_w (reg_wr_en_W),
    .o_sel  (w_fwd_a)
  );

  hazard_fwd_sel u_fwd_b (
    .i_rs   (instr_E[24:20]),
    .i_rd_m (instr_M[11:7]),
    .i_wr_m (reg_wr_en_M),
    .i_rd_w (instr_W[11:7]),
    .i_wr_w (reg_wr_en_W),
    .o_sel  (w_fwd_b)
  );

  assign w_load_use  = (w_opc_E == LOAD) && reg_wr_en_E && (w_rd_E != 5'd0) &&
                       ((w_rd_E == instr_D[19:15]) || (w_rd_E == instr_D[24:20]));
  assign w_redirect  = is_taken &&
                       ((w_opc_E == BRANCH) || (w_opc_E == JAL) || (w_opc_E == JALR));
  assign w_mdu_stall = MDU_EN && mdu_busy && !mdu_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pc_en     = 1'b1;
    w_ifid_en   = 1'b1;
    w_idex_en   = 1'b1;
    w_exme_en   = 1'b1;
    w_mewb_en   = 1'b1;
    w_ifid_fl   = 1'b0;
    w_idex_fl   = 1'b0;
    w_exme_fl   = 1'b0;
    w_mewb_fl   = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mdu_stall) begin
          w_state_nxt = MDU_WAIT;
          w_pc_en     = 1'b0;
          w_ifid_en   = 1'b0;
          w_idex_en   = 1'b0;
          w_exme_fl   = 1'b1;
        end else if (w_redirect) begin
          w_ifid_fl = 1'b1;
          w_idex_fl = 1'b1;
        end else if (w_load_use) begin
          w_pc_en   = 1'b0;
          w_ifid_en = 1'b0;
          w_idex_fl = 1'b1;
          if (LOAD_STALL > 1) begin
            w_state_nxt = LD_STALL;
            w_cnt_nxt   = LD_INIT;
          end
        end
      end
      LD_STALL: begin
        w_pc_en   = 1'b0;
        w_ifid_en = 1'b0;
        w_idex_fl = 1'b1;
        // The RUN entry cycle already counted as one bubble
        if (r_cnt <= 2'd1) begin
          w_cnt_nxt   = 2'd0;
          w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      MDU_WAIT: begin
        if (mdu_done) begin
          w_state_nxt = RUN;
        end else begin
          w_pc_en   = 1'b0;
          w_ifid_en = 1'b0;
          w_idex_en = 1'b0;
          w_exme_fl = 1'b1;
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  // Reset forces a full pipeline clear regardless of the FSM
  assign pc_enable    = rst_n & w_pc_en;
  assign IF_ID_enable = rst_n & w_ifid_en;
  assign ID_EX_enable = rst_n & w_idex_en;
  assign EX_ME_enable = rst_n & w_exme_en;
  assign ME_WB_enable = rst_n & w_mewb_en;
  assign IF_ID_flush  = ~rst_n | w_ifid_fl;
  assign ID_EX_flush  = ~rst_n | w_idex_fl;
  assign EX_ME_flush  = ~rst_n | w_exme_fl;
  assign ME_WB_flush  = ~rst_n | w_mewb_fl;
  assign forward_opA  = rst_n ? w_fwd_a : 2'b00;
  assign forward_opB  = rst_n ? w_fwd_b : 2'b00;
  assign hz_state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_ctrl : directed vectors for hazard_ctrl (LOAD_STALL=2, MDU_EN=1)
// Rev 1.0
// ============================================================================
module tb_hazard_ctrl;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  // {pc, IF_ID_en, ID_EX_en, EX_ME_en, ME_WB_en, IF_ID_fl, ID_EX_fl, EX_ME_fl, ME_WB_fl}
  localparam logic [8:0] C_RST   = 9'b00000_1111;
  localparam logic [8:0] C_RUN   = 9'b11111_0000;
  localparam logic [8:0] C_STALL = 9'b00111_0100;
  localparam logic [8:0] C_REDIR = 9'b11111_1100;
  localparam logic [8:0] C_MDU   = 9'b00011_0010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_D, instr_E, instr_M, instr_W;
  logic        reg_wr_en_E, reg_wr_en_M, reg_wr_en_W;
  logic        is_taken, mdu_busy, mdu_done;
  logic [1:0]  forward_opA, forward_opB, hz_state;
  logic        pc_enable, IF_ID_enable, ID_EX_enable, EX_ME_enable, ME_WB_enable;
  logic        IF_ID_flush, ID_EX_flush, EX_ME_flush, ME_WB_flush;

  int n_checks = 0;
  int n_errors = 0;

  wire [8:0] ctrl = {pc_enable, IF_ID_enable, ID_EX_enable, EX_ME_enable, ME_WB_enable,
                     IF_ID_flush, ID_EX_flush, EX_ME_flush, ME_WB_flush};

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL(2), .MDU_EN(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_D      (instr_D),
    .instr_E      (instr_E),
    .instr_M      (instr_M),
    .instr_W      (instr_W),
    .reg_wr_en_E  (reg_wr_en_E),
    .reg_wr_en_M  (reg_wr_en_M),
    .reg_wr_en_W  (reg_wr_en_W),
    .is_taken     (is_taken),
    .mdu_busy     (mdu_busy),
    .mdu_done     (mdu_done),
    .forward_opA  (forward_opA),
    .forward_opB  (forward_opB),
    .pc_enable    (pc_enable),
    .IF_ID_enable (IF_ID_enable),
    .ID_EX_enable (ID_EX_enable),
    .EX_ME_enable (EX_ME_enable),
    .ME_WB_enable (ME_WB_enable),
    .IF_ID_flush  (IF_ID_flush),
    .ID_EX_flush  (ID_EX_flush),
    .EX_ME_flush  (EX_ME_flush),
    .ME_WB_flush  (ME_WB_flush),
    .hz_state     (hz_state)
  );

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    mk = {7'd0, rs2, rs1, 3'd0, rd, opc};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    instr_D = '0; instr_M = '0; instr_W = '0;
    instr_E = mk(OP_ALU, 5'd9, 5'd5, 5'd6);
    instr_M = mk(OP_ALU, 5'd5, 5'd1, 5'd1);
    reg_wr_en_E = 1'b0; reg_wr_en_M = 1'b1; reg_wr_en_W = 1'b0;
    is_taken = 1'b0; mdu_busy = 1'b0; mdu_done = 1'b0;

    #3;
    check("rst_ctrl",  32'(ctrl), 32'(C_RST));
    check("rst_state", 32'(hz_state), 0);
    check("rst_fwdA",  32'(forward_opA), 0);

    @(negedge clk) rst_n = 1'b1;
    tick();

    // forwarding
    instr_W = mk(OP_ALU, 5'd5, 5'd1, 5'd1); reg_wr_en_W = 1'b1;
    #2;
    check("fwd_A_mem",  32'(forward_opA), 1);
    check("fwd_B_none", 32'(forward_opB), 0);
    check("run_ctrl",   32'(ctrl), 32'(C_RUN));
    instr_W = mk(OP_ALU, 5'd6, 5'd1, 5'd1);
    #2;
    check("fwd_B_wb",   32'(forward_opB), 2);
    check("fwd_A_mem2", 32'(forward_opA), 1);
    instr_W = mk(OP_ALU, 5'd5, 5'd1, 5'd1); reg_wr_en_M = 1'b0;
    #2;
    check("fwd_A_wb",   32'(forward_opA), 2);
    reg_wr_en_W = 1'b0;
    #2;
    check("fwd_A_nowr", 32'(forward_opA), 0);
    instr_E = mk(OP_ALU, 5'd9, 5'd0, 5'd0);
    instr_M = mk(OP_ALU, 5'd0, 5'd1, 5'd1);
    instr_W = mk(OP_ALU, 5'd0, 5'd1, 5'd1);
    reg_wr_en_M = 1'b1; reg_wr_en_W = 1'b1;
    #2;
    check("fwd_A_x0",   32'(forward_opA), 0);
    check("fwd_B_x0",   32'(forward_opB), 0);
    instr_E = '0; instr_M = '0; instr_W = '0; reg_wr_en_M = 1'b0; reg_wr_en_W = 1'b0;
    tick();

    // load-use on rs1, two bubbles
    instr_E = mk(OP_LOAD, 5'd7, 5'd2, 5'd0); reg_wr_en_E = 1'b1;
    instr_D = mk(OP_ALU, 5'd8, 5'd7, 5'd1);
    #2;
    check("lu_c1_ctrl",  32'(ctrl), 32'(C_STALL));
    check("lu_c1_state", 32'(hz_state), 0);
    tick();
    instr_E = '0; reg_wr_en_E = 1'b0;
    #2;
    check("lu_c2_ctrl",  32'(ctrl), 32'(C_STALL));
    check("lu_c2_state", 32'(hz_state), 1);
    tick();
    #2;
    check("lu_end_ctrl",  32'(ctrl), 32'(C_RUN));
    check("lu_end_state", 32'(hz_state), 0);

    // no hazard when load targets x0 or does not write
    instr_E = mk(OP_LOAD, 5'd0, 5'd2, 5'd0); reg_wr_en_E = 1'b1;
    instr_D = mk(OP_ALU, 5'd8, 5'd0, 5'd1);
    #2;
    check("lu_x0", 32'(ctrl), 32'(C_RUN));
    instr_E = mk(OP_LOAD, 5'd7, 5'd2, 5'd0); reg_wr_en_E = 1'b0;
    instr_D = mk(OP_ALU, 5'd8, 5'd7, 5'd1);
    #2;
    check("lu_nowr", 32'(ctrl), 32'(C_RUN));

    // load-use on rs2
    instr_E = mk(OP_LOAD, 5'd1, 5'd2, 5'd0); reg_wr_en_E = 1'b1;
    #2;
    check("lu_rs2_ctrl", 32'(ctrl), 32'(C_STALL));
    tick();
    instr_E = '0; reg_wr_en_E = 1'b0;
    #2;
    check("lu_rs2_state", 32'(hz_state), 1);
    tick();
    #2;
    check("lu_rs2_end", 32'(hz_state), 0);

    // taken branch with dependent instruction in D
    instr_E = mk(OP_BR, 5'd7, 5'd1, 5'd2); reg_wr_en_E = 1'b1; is_taken = 1'b1;
    instr_D = mk(OP_ALU, 5'd8, 5'd7, 5'd1);
    #2;
    check("br_ctrl",  32'(ctrl), 32'(C_REDIR));
    check("br_state", 32'(hz_state), 0);
    tick();
    instr_E = '0; reg_wr_en_E = 1'b0; is_taken = 1'b0;
    #2;
    check("br_after_ctrl",  32'(ctrl), 32'(C_RUN));
    check("br_after_state", 32'(hz_state), 0);
    instr_E = mk(OP_JALR, 5'd1, 5'd5, 5'd0); is_taken = 1'b1;
    #2;
    check("jalr_ctrl", 32'(ctrl), 32'(C_REDIR));
    instr_E = mk(OP_ALU, 5'd1, 5'd5, 5'd0);
    #2;
    check("taken_alu", 32'(ctrl), 32'(C_RUN));
    instr_E = '0; is_taken = 1'b0; instr_D = '0;
    tick();

    // MDU wait of four cycles
    mdu_busy = 1'b1;
    #2;
    check("mdu_c1_ctrl",  32'(ctrl), 32'(C_MDU));
    check("mdu_c1_state", 32'(hz_state), 0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      if (i == 3) begin
        instr_E = mk(OP_BR, 5'd0, 5'd1, 5'd2); is_taken = 1'b1;
      end else begin
        instr_E = '0; is_taken = 1'b0;
      end
      #2;
      check("mdu_wait_ctrl",  32'(ctrl), 32'(C_MDU));
      check("mdu_wait_state", 32'(hz_state), 2);
    end
    tick();
    mdu_done = 1'b1;
    #2;
    check("mdu_done_ctrl",  32'(ctrl), 32'(C_RUN));
    check("mdu_done_state", 32'(hz_state), 2);
    tick();
    mdu_busy = 1'b0; mdu_done = 1'b0;
    #2;
    check("mdu_exit_state", 32'(hz_state), 0);

    // busy and done together: zero stall
    mdu_busy = 1'b1; mdu_done = 1'b1;
    #2;
    check("mdu_fast_ctrl", 32'(ctrl), 32'(C_RUN));
    tick();
    mdu_busy = 1'b0; mdu_done = 1'b0;
    #2;
    check("mdu_fast_state", 32'(hz_state), 0);

    // reset during MDU wait
    mdu_busy = 1'b1;
    tick();
    tick();
    #2;
    check("mdu_pre_rst", 32'(hz_state), 2);
    rst_n = 1'b0;
    #1;
    check("arst_ctrl",  32'(ctrl), 32'(C_RST));
    check("arst_state", 32'(hz_state), 0);
    @(negedge clk);
    rst_n = 1'b1; mdu_busy = 1'b0;
    tick();
    #2;
    check("post_rst_ctrl",  32'(ctrl), 32'(C_RUN));
    check("post_rst_state", 32'(hz_state), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter LOAD_STALL, default 1, range 1..3: bubble cycles inserted per load-use hazard.
REQ-002 Parameter MDU_EN, default 1: 0 ties MDU wait logic off, and mdu_busy/mdu_done are ignored.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 instr_D, instr_E, instr_M, instr_W  in  32 each  instruction in the Decode, Execute, Memory and Writeback stages.
REQ-006 reg_wr_en_E, reg_wr_en_M, reg_wr_en_W  in  1 each  register-write enable of that stage.
REQ-007 is_taken  in  1  branch/jump resolved taken in E.
REQ-008 mdu_busy  in  1  multi-cycle mul/div occupying E; mdu_done  in  1  result valid this cycle.
REQ-009 forward_opA, forward_opB  out  2 each  operand source: 00 regfile, 01 M, 10 W.
REQ-010 pc_enable, IF_ID_enable, ID_EX_enable, EX_ME_enable, ME_WB_enable  out  1 each  stage register enables.
REQ-011 IF_ID_flush, ID_EX_flush, EX_ME_flush, ME_WB_flush  out  1 each  stage register clears.
REQ-012 hz_state  out  2  current FSM state: 0 RUN, 1 LD_STALL, 2 MDU_WAIT.

Function
REQ-013 Forwarding is combinational and independent per operand; rs1/rs2 = instr_E[19:15]/[24:20], rd = [11:7].
REQ-014 forward_opX = 01 when reg_wr_en_M, rd_M != 0 and rd_M == rsX_E; else 10 when reg_wr_en_W, rd_W != 0 and rd_W == rsX_E; else 00. M has priority over W.
REQ-015 Every output is driven on every path; no latches.
REQ-016 Load-use hazard: instr_E opcode 0000011, reg_wr_en_E, rd_E != 0, and rd_E equals instr_D rs1 or rs2.
REQ-017 In RUN, a load-use hazard starts the stall in the same cycle: pc_enable=0, IF_ID_enable=0, ID_EX_flush=1, EX_ME_enable=1, ME_WB_enable=1.
REQ-018 If LOAD_STALL > 1, the FSM enters LD_STALL with counter = LOAD_STALL-1; otherwise it stays in RUN.
REQ-019 LD_STALL holds the REQ-017 outputs each cycle and decrements the counter; at 0 the FSM returns to RUN.
REQ-020 Total stall for one hazard is exactly LOAD_STALL cycles.
REQ-021 Redirect: in RUN, when is_taken and instr_E opcode is 1100011, 1101111 or 1100111, then IF_ID_flush=1 and ID_EX_flush=1 for one cycle, with pc_enable=1.
REQ-022 Redirect has priority over a load-use hazard seen in D in the same cycle; the stall is not entered.
REQ-023 MDU: in RUN, when MDU_EN, mdu_busy and !mdu_done, the FSM enters MDU_WAIT.
REQ-024 In the entry cycle and throughout MDU_WAIT: pc_enable=0, IF_ID_enable=0, ID_EX_enable=0, EX_ME_flush=1, ME_WB_enable=1.
REQ-025 MDU_WAIT exits to RUN in the cycle mdu_done=1; that cycle drives the RUN outputs.
REQ-026 mdu_busy with mdu_done already high in the same cycle costs zero stall cycles.
REQ-027 MDU_WAIT has priority over redirect and load-use; a redirect is evaluated only after the exit.
REQ-028 Default RUN outputs: all enables 1, all flushes 0.
REQ-029 The LD_STALL counter is 2 bits and never wraps below 0.

Reset
REQ-030 While rst_n=0: state=RUN, counter=0, all enables 0, all flushes 1, forward_opA/B=00.
REQ-031 Assertion of rst_n mid-stall or mid-MDU_WAIT aborts immediately; the first cycle after release is RUN with default outputs.

Structure
REQ-032 Package hazard_pkg holds:
- opcode constants (LOAD, BRANCH, JAL, JALR);
- fwd_sel enum (REGF, MEM, WB);
- hz_state enum.
REQ-033 Sub-module hazard_fwd_sel computes one operand select and is instantiated twice, for A and B.

Verification
REQ-034 instr_E rs1=5, instr_M rd=5 write, instr_W rd=5 write -> forward_opA=01; M write off -> 10; rd=0 everywhere -> 00.
REQ-035 LOAD_STALL=2, instr_E lw x7, instr_D add x8,x7,x1 -> pc_enable=0 for exactly 2 cycles, ID_EX_flush=1 both cycles, hz_state 0->1->0.
REQ-036 Taken beq in E coinciding with a load-use pattern in D -> single-cycle IF_ID_flush=ID_EX_flush=1, no stall, hz_state stays 0.
REQ-037 mdu_busy=1 for 4 cycles, then mdu_done -> pc_enable=0 and EX_ME_flush=1 for 4 cycles, resume the next cycle; mdu_busy with mdu_done in the same cycle -> no stall.
REQ-038 rst_n pulsed low during cycle 2 of MDU_WAIT -> outputs go to reset values asynchronously; after release hz_state=0 with default RUN outputs.
